vc_writeback_buffer: RTL and testbench

Dirty-line write-back buffer downstream of the victim cache. When a full victim cache displaces a valid dirty line, the line is pushed here. The buffer queues it, drains it to main memory through a single-outstanding request/ack handshake, and answers address snoops from the L1 miss path. The snoops prevent a refill from reading stale memory while a dirty line is still in flight.

---
 rtl/cache_def.sv | 20 ++
 rtl/adder_32bit.sv | 10 +
 rtl/vc_wb_entry_array.sv | 118 +++++++++++
 rtl/vc_writeback_buffer.sv | 128 ++++++++++++
 tb/tb_vc_writeback_buffer.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_def.sv
// Shared types and line-address constants for the victim-cache write-back path.
package cache_def;

  localparam int unsigned CD_ADDR_W      = 32;
  localparam int unsigned CD_LINE_W      = 128;
  localparam int unsigned CD_OFFSET_W    = 4;
  localparam int unsigned CD_LINE_ADDR_W = CD_ADDR_W - CD_OFFSET_W;

  typedef struct packed {
    logic                      valid;
    logic [CD_LINE_ADDR_W-1:0] line_addr;
    logic [CD_LINE_W-1:0]      data;
  } vc_wb_entry_type;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } vc_wb_state_type;

endpackage

// File: rtl/adder_32bit.sv
// Plain 32-bit wrapping adder shared across the cache subsystem.
module adder_32bit (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] sum_o
);

  assign sum_o = a_i + b_i;

endmodule

// File: rtl/vc_wb_entry_array.sv
// Circular line store with pointers, occupancy and snoop comparators.
// VC_WB_COALESCE_EN enables in-place merging of pushes into non-head entries.
module vc_wb_entry_array
  import cache_def::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      push_i,
  input  logic [CD_LINE_ADDR_W-1:0] push_line_i,
  input  logic [CD_LINE_W-1:0]      push_data_i,
  input  logic                      pop_i,
  output logic                      full_o,
  output logic                      empty_o,
  output logic                      coal_hit_o,
  output vc_wb_entry_type           head_o,
  output vc_wb_entry_type           next_o,
  input  logic                      snoop_valid_i,
  input  logic [CD_LINE_ADDR_W-1:0] snoop_line_i,
  output logic                      snoop_hit_o,
  output logic [CD_LINE_W-1:0]      snoop_data_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  vc_wb_entry_type  entries_r [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [PTR_W-1:0] nxt_ptr_s;
  logic [PTR_W-1:0] wr_slot_s;
  logic [PTR_W-1:0] coal_idx_s;
  logic             coal_hit_s;
  logic             alloc_s;

  assign full_o     = (count_r == CNT_W'(DEPTH));
  assign empty_o    = (count_r == {CNT_W{1'b0}});
  assign nxt_ptr_s  = rd_ptr_r + PTR_W'(1);
  assign head_o     = entries_r[rd_ptr_r];
  assign coal_hit_o = coal_hit_s;
  assign alloc_s    = push_i && !coal_hit_s;
  assign wr_slot_s  = coal_hit_s ? coal_idx_s : wr_ptr_r;

  // Merge target search; the head is excluded because it is (or is about to be) in flight
  always_comb begin
    coal_hit_s = 1'b0;
    coal_idx_s = rd_ptr_r;
`ifdef VC_WB_COALESCE_EN
    for (int i = 1; i < int'(DEPTH); i++) begin
      if (entries_r[rd_ptr_r + PTR_W'(i)].valid &&
          (entries_r[rd_ptr_r + PTR_W'(i)].line_addr == push_line_i)) begin
        coal_hit_s = 1'b1;
        coal_idx_s = rd_ptr_r + PTR_W'(i);
      end else begin
        coal_hit_s = coal_hit_s;
      end
    end
`endif
  end

  // Entry after the head, forwarding a same-edge write so back-to-back sends never see stale data
  always_comb begin
    next_o = entries_r[nxt_ptr_s];
    if (push_i && (wr_slot_s == nxt_ptr_s)) begin
      next_o.valid     = 1'b1;
      next_o.line_addr = push_line_i;
      next_o.data      = push_data_i;
    end else begin
      next_o = entries_r[nxt_ptr_s];
    end
  end

  // Snoop scan from oldest to youngest so the youngest match wins
  always_comb begin
    snoop_hit_o  = 1'b0;
    snoop_data_o = {CD_LINE_W{1'b0}};
    if (snoop_valid_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (entries_r[rd_ptr_r + PTR_W'(i)].valid &&
            (entries_r[rd_ptr_r + PTR_W'(i)].line_addr == snoop_line_i)) begin
          snoop_hit_o  = 1'b1;
          snoop_data_o = entries_r[rd_ptr_r + PTR_W'(i)].data;
        end else begin
          snoop_hit_o = snoop_hit_o;
        end
      end
    end else begin
      snoop_hit_o = 1'b0;
    end
  end

  // Storage, pointer and occupancy update
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        entries_r[i] <= '0;
      end
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (pop_i) begin
        entries_r[rd_ptr_r].valid <= 1'b0;
        rd_ptr_r                  <= nxt_ptr_s;
      end
      if (push_i) begin
        entries_r[wr_slot_s] <= '{valid: 1'b1, line_addr: push_line_i, data: push_data_i};
      end
      if (alloc_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      count_r <= count_r + CNT_W'(alloc_s) - CNT_W'(pop_i);
    end
  end

endmodule

// File: rtl/vc_writeback_buffer.sv
// Dirty-line write-back buffer: queues victims, drains them to memory, answers L1 snoops.
// Optional VC_WB_COALESCE_EN (inside vc_wb_entry_array) merges repeat pushes of a queued line.
module vc_writeback_buffer
  import cache_def::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ADDR_W   = CD_ADDR_W,
  parameter int unsigned LINE_W   = CD_LINE_W,
  parameter int unsigned OFFSET_W = CD_OFFSET_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wb_valid_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [LINE_W-1:0] wb_data_i,
  output logic              wb_ready_o,
  output logic              mem_req_valid_o,
  output logic              mem_req_rw_o,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  output logic [LINE_W-1:0] mem_req_data_o,
  input  logic              mem_ack_i,
  input  logic              snoop_valid_i,
  input  logic [ADDR_W-1:0] snoop_addr_i,
  output logic              snoop_hit_o,
  output logic [LINE_W-1:0] snoop_data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [31:0]       no_wb_o
);

  localparam int unsigned LA_W = ADDR_W - OFFSET_W;

  vc_wb_state_type  state_r;
  logic             req_valid_r;
  logic [LA_W-1:0]  req_line_r;
  logic [LINE_W-1:0] req_data_r;
  logic [31:0]      no_wb_r;
  logic [31:0]      no_wb_inc_s;
  logic             full_s;
  logic             empty_s;
  logic             coal_hit_s;
  logic             wb_ready_s;
  logic             push_s;
  logic             pop_s;
  vc_wb_entry_type  head_s;
  vc_wb_entry_type  next_s;
  logic             unused_bits_s;

  // coal_hit_s is constant 0 unless merging is compiled in
  assign wb_ready_s    = !full_s || coal_hit_s;
  assign push_s        = wb_valid_i && wb_ready_s;
  assign pop_s         = (state_r == SEND) && mem_ack_i;
  assign unused_bits_s = ^{wb_addr_i[OFFSET_W-1:0], snoop_addr_i[OFFSET_W-1:0], head_s.valid};

  vc_wb_entry_array #(
    .DEPTH(DEPTH)
  ) u_entry_array (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .push_i       (push_s),
    .push_line_i  (wb_addr_i[ADDR_W-1:OFFSET_W]),
    .push_data_i  (wb_data_i),
    .pop_i        (pop_s),
    .full_o       (full_s),
    .empty_o      (empty_s),
    .coal_hit_o   (coal_hit_s),
    .head_o       (head_s),
    .next_o       (next_s),
    .snoop_valid_i(snoop_valid_i),
    .snoop_line_i (snoop_addr_i[ADDR_W-1:OFFSET_W]),
    .snoop_hit_o  (snoop_hit_o),
    .snoop_data_o (snoop_data_o)
  );

  adder_32bit u_wb_count_adder (
    .a_i  (no_wb_r),
    .b_i  (32'd1),
    .sum_o(no_wb_inc_s)
  );

  // Drain FSM with registered memory request and completion counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= IDLE;
      req_valid_r <= 1'b0;
      req_line_r  <= {LA_W{1'b0}};
      req_data_r  <= {LINE_W{1'b0}};
      no_wb_r     <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (!empty_s) begin
            state_r     <= SEND;
            req_valid_r <= 1'b1;
            req_line_r  <= head_s.line_addr;
            req_data_r  <= head_s.data;
          end
        end
        SEND: begin
          if (mem_ack_i) begin
            no_wb_r <= no_wb_inc_s;
            if (next_s.valid) begin
              req_line_r <= next_s.line_addr;
              req_data_r <= next_s.data;
            end else begin
              state_r     <= IDLE;
              req_valid_r <= 1'b0;
            end
          end
        end
        default: begin
          state_r     <= IDLE;
          req_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign wb_ready_o      = wb_ready_s;
  assign full_o          = full_s;
  assign empty_o         = empty_s;
  assign mem_req_valid_o = req_valid_r;
  assign mem_req_rw_o    = 1'b1;
  assign mem_req_addr_o  = {req_line_r, {OFFSET_W{1'b0}}};
  assign mem_req_data_o  = req_data_r;
  assign no_wb_o         = no_wb_r;

endmodule

// File: tb/tb_vc_writeback_buffer.sv
// Self-checking bench for vc_writeback_buffer: queue-based reference model plus directed cases.
module tb_vc_writeback_buffer;

  localparam int DEPTH = 4;
`ifdef VC_WB_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif

  typedef struct {
    logic [27:0]  line;
    logic [127:0] data;
  } ent_t;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         wb_valid_i = 1'b0;
  logic [31:0]  wb_addr_i = 32'd0;
  logic [127:0] wb_data_i = 128'd0;
  logic         wb_ready_o;
  logic         mem_req_valid_o;
  logic         mem_req_rw_o;
  logic [31:0]  mem_req_addr_o;
  logic [127:0] mem_req_data_o;
  logic         mem_ack_i = 1'b0;
  logic         snoop_valid_i = 1'b0;
  logic [31:0]  snoop_addr_i = 32'd0;
  logic         snoop_hit_o;
  logic [127:0] snoop_data_o;
  logic         full_o;
  logic         empty_o;
  logic [31:0]  no_wb_o;

  always #5 clk_i = ~clk_i;

  vc_writeback_buffer dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .wb_valid_i     (wb_valid_i),
    .wb_addr_i      (wb_addr_i),
    .wb_data_i      (wb_data_i),
    .wb_ready_o     (wb_ready_o),
    .mem_req_valid_o(mem_req_valid_o),
    .mem_req_rw_o   (mem_req_rw_o),
    .mem_req_addr_o (mem_req_addr_o),
    .mem_req_data_o (mem_req_data_o),
    .mem_ack_i      (mem_ack_i),
    .snoop_valid_i  (snoop_valid_i),
    .snoop_addr_i   (snoop_addr_i),
    .snoop_hit_o    (snoop_hit_o),
    .snoop_data_o   (snoop_data_o),
    .full_o         (full_o),
    .empty_o        (empty_o),
    .no_wb_o        (no_wb_o)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  ent_t        q[$];
  bit          m_req = 1'b0;
  logic [31:0] m_no_wb = 32'd0;
  bit          proto_allow = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Index of the youngest non-head queued entry with this line (merge target), or -1
  function automatic int coal_idx(input logic [27:0] line);
    int r = -1;
    for (int j = 1; j < q.size(); j++) begin
      if (COAL && (q[j].line == line)) r = j;
    end
    return r;
  endfunction

  function automatic bit m_ready();
    return (q.size() < DEPTH) || (coal_idx(wb_addr_i[31:4]) >= 0);
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference model: queue of lines, request valid flag, completion count
  always @(posedge clk_i) begin : model
    int sz;
    int cj;
    bit acc;
    bit pop;
    if (!rst_ni) begin
      q.delete();
      m_req   = 1'b0;
      m_no_wb = 32'd0;
    end else begin
      sz  = q.size();
      cj  = coal_idx(wb_addr_i[31:4]);
      acc = wb_valid_i && ((sz < DEPTH) || (cj >= 0));
      pop = m_req && mem_ack_i;
      if (pop) begin
        q.delete(0);
        m_no_wb = m_no_wb + 32'd1;
        if (cj > 0) cj--;
      end
      if (acc) begin
        if (cj >= 0) q[cj].data = wb_data_i;
        else q.push_back('{line: wb_addr_i[31:4], data: wb_data_i});
      end
      if (pop) m_req = (q.size() > 0);
      else if (!m_req && (sz > 0)) m_req = 1'b1;
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk_i) begin : cmp
    logic         exp_hit;
    logic [127:0] exp_sd;
    if (rst_ni) begin
      exp_hit = 1'b0;
      exp_sd  = 128'd0;
      if (snoop_valid_i) begin
        for (int i = 0; i < q.size(); i++) begin
          if (q[i].line == snoop_addr_i[31:4]) begin
            exp_hit = 1'b1;
            exp_sd  = q[i].data;
          end
        end
      end
      chk("wb_ready", wb_ready_o, m_ready());
      chk("full", full_o, q.size() == DEPTH);
      chk("empty", empty_o, q.size() == 0);
      chk("req_valid", mem_req_valid_o, m_req);
      chk("req_rw", mem_req_rw_o, 1'b1);
      if (m_req) begin
        chk("req_addr", mem_req_addr_o, {q[0].line, 4'h0});
        chk("req_data", mem_req_data_o, q[0].data);
      end
      chk("no_wb", no_wb_o, m_no_wb);
      chk("snoop_hit", snoop_hit_o, exp_hit);
      if (exp_hit) chk("snoop_data", snoop_data_o, exp_sd);
      if (wb_valid_i) chk("push_protocol", proto_allow || wb_ready_o, 1'b1);
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni        = 1'b0;
    wb_valid_i    = 1'b0;
    mem_ack_i     = 1'b0;
    snoop_valid_i = 1'b0;
    proto_allow   = 1'b0;
    cyc();
    cyc();
    rst_ni = 1'b1;
  endtask

  task automatic push_now(input logic [31:0] a, input logic [127:0] d);
    wb_valid_i = 1'b1;
    wb_addr_i  = a;
    wb_data_i  = d;
    cyc();
    wb_valid_i = 1'b0;
  endtask

  logic [127:0] dl [1:5];

  initial begin
    for (int k = 1; k <= 5; k++) dl[k] = rnd128();

    // Reset state
    do_reset();
    cyc();
    chk("rst_empty", empty_o, 1'b1);
    chk("rst_ready", wb_ready_o, 1'b1);
    chk("rst_req_valid", mem_req_valid_o, 1'b0);
    chk("rst_no_wb", no_wb_o, 32'd0);

    // Single line, ack held off for three cycles
    push_now(32'h0000_1230, {16{8'hA5}});
    chk("t2_req_not_yet", mem_req_valid_o, 1'b0);
    chk("t2_not_empty", empty_o, 1'b0);
    cyc();
    chk("t2_req_valid", mem_req_valid_o, 1'b1);
    chk("t2_req_addr", mem_req_addr_o, 32'h0000_1230);
    chk("t2_req_data", mem_req_data_o, {16{8'hA5}});
    cyc();
    cyc();
    chk("t2_hold_addr", mem_req_addr_o, 32'h0000_1230);
    chk("t2_hold_valid", mem_req_valid_o, 1'b1);
    mem_ack_i = 1'b1;
    cyc();
    mem_ack_i = 1'b0;
    chk("t2_no_wb", no_wb_o, 32'd1);
    chk("t2_empty", empty_o, 1'b1);
    chk("t2_req_done", mem_req_valid_o, 1'b0);

    // Fill to DEPTH, then back-to-back drain
    do_reset();
    for (int k = 1; k <= 4; k++) push_now(32'(k) << 8, dl[k]);
    chk("t3_full", full_o, 1'b1);
    chk("t3_ready", wb_ready_o, 1'b0);
    mem_ack_i = 1'b1;
    for (int k = 2; k <= 4; k++) begin
      cyc();
      chk("t3_drain_valid", mem_req_valid_o, 1'b1);
      chk("t3_drain_addr", mem_req_addr_o, 32'(k) << 8);
    end
    cyc();
    mem_ack_i = 1'b0;
    chk("t3_drain_end", mem_req_valid_o, 1'b0);
    chk("t3_no_wb", no_wb_o, 32'd4);

    // Push while full on the ack edge is rejected; next cycle it is accepted
    do_reset();
    for (int k = 1; k <= 4; k++) push_now(32'(k) << 8, dl[k]);
    proto_allow = 1'b1;
    wb_valid_i  = 1'b1;
    wb_addr_i   = 32'h0000_0500;
    wb_data_i   = dl[5];
    mem_ack_i   = 1'b1;
    cyc();
    proto_allow = 1'b0;
    mem_ack_i   = 1'b0;
    chk("t4_not_full", full_o, 1'b0);
    chk("t4_ready", wb_ready_o, 1'b1);
    chk("t4_head", mem_req_addr_o, 32'h0000_0200);
    cyc();
    wb_valid_i = 1'b0;
    chk("t4_refull", full_o, 1'b1);
    snoop_valid_i = 1'b1;
    snoop_addr_i  = 32'h0000_0308;
    #1;
    chk("t4_snoop_hit", snoop_hit_o, 1'b1);
    chk("t4_snoop_data", snoop_data_o, dl[3]);
    snoop_addr_i = 32'h0000_0600;
    #1;
    chk("t4_snoop_miss", snoop_hit_o, 1'b0);
    snoop_addr_i = 32'h0000_0200;
    mem_ack_i    = 1'b1;
    #1;
    chk("t4_snoop_head_ack", snoop_hit_o, 1'b1);
    chk("t4_snoop_head_data", snoop_data_o, dl[2]);
    cyc();
    chk("t4_snoop_popped", snoop_hit_o, 1'b0);
    snoop_valid_i = 1'b0;
    repeat (3) cyc();
    mem_ack_i = 1'b0;
    chk("t4_no_wb", no_wb_o, 32'd5);
    chk("t4_empty", empty_o, 1'b1);

    // Repeat push of a queued line
    do_reset();
    push_now(32'h0000_0100, dl[1]);
    push_now(32'h0000_0200, dl[2]);
    push_now(32'h0000_0200, dl[3]);
    mem_ack_i = 1'b1;
    cyc();
    chk("t5_second_addr", mem_req_addr_o, 32'h0000_0200);
`ifdef VC_WB_COALESCE_EN
    chk("t5_merged_data", mem_req_data_o, dl[3]);
    cyc();
    chk("t5_done", mem_req_valid_o, 1'b0);
    chk("t5_no_wb", no_wb_o, 32'd2);
`else
    chk("t5_first_dup_data", mem_req_data_o, dl[2]);
    cyc();
    chk("t5_second_dup_data", mem_req_data_o, dl[3]);
    cyc();
    chk("t5_done", mem_req_valid_o, 1'b0);
    chk("t5_no_wb", no_wb_o, 32'd3);
`endif
    mem_ack_i = 1'b0;

    // Randomised traffic, with one reset dropped in mid-stream
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      wb_addr_i  = 32'h0000_1000 | (32'($urandom_range(0, 7)) << 4) | 32'($urandom_range(0, 15));
      wb_data_i  = rnd128();
      wb_valid_i = ($urandom_range(0, 1) == 1) && m_ready();
      mem_ack_i  = ($urandom_range(0, 2) == 0);
      snoop_valid_i = ($urandom_range(0, 3) != 0);
      snoop_addr_i  = 32'h0000_1000 | (32'($urandom_range(0, 8)) << 4) | 32'($urandom_range(0, 15));
      cyc();
    end
    wb_valid_i = 1'b0;
    mem_ack_i  = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
